led_word_scroller: RTL and testbench
====================================

Name: led_word_scroller

Overview:
Parametrised successor to the LED word rotator. It captures an N-bit word (e.g. a PUF response) and shows it W bits at a time on the board LEDs. Window selection is index-based, so N does not need to be a multiple of W. Adds runtime dwell, pause/auto/manual modes, direction control, a window-index output and a wrap pulse. Sits between the PUF response register and the board LED/debug pins.

Parameters:
N, 264, captured word width (>=1)
W, 8, LED/window width (>=1)
DWELL_W, 30, width of the dwell counter and `dwell` input
Derived, not overridable: NWIN = ceil(N/W); IDX_W = max(1, clog2(NWIN)); padded word = {zeros, data}, NWIN*W bits

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
load  in  1  capture data_in; highest synchronous priority
data_in  in  N  word to display
mode  in  2  00 pause, 01 auto, 10 manual, 11 reserved (treated as pause)
dir  in  1  0 forward (index increments), 1 backward
step  in  1  manual advance request, level input, internally edge-detected
dwell  in  DWELL_W  auto mode: advance when counter >= dwell (period dwell+1 cycles)
leds  out  W  padded[idx*W +: W]
win_idx  out  IDX_W  current window index
wrap  out  1  one-cycle pulse when the index wraps

Behaviour:
- One clock; reset is asynchronous and active-high: clk and rst.
- rst asserted, at any time including mid-operation, immediately clears: buffer, idx, counter, step_q, wrap. Consequently leds=0 and win_idx=0.
- leds and win_idx are combinational decodes of registered buffer/idx. They change in the same cycle as the registers update, with no added latency.
- Priority each clock edge: rst > load > mode action.
- load=1:
  - buffer <= zero-padded data_in; idx <= 0; counter <= 0; wrap <= 0.
  - Any advance due in the same cycle is discarded.
- Edge detector: step_q <= step every cycle in all modes, including during load. step_rise = step & ~step_q.
  - Holding step high gives exactly one advance.
  - Switching into manual while step is high gives no advance.
- Pause (00/11): idx and counter held; wrap=0.
- Auto (01):
  - If counter >= dwell: counter <= 0 and advance. Otherwise counter <= counter+1.
  - dwell=0 means advance every cycle.
  - Lowering dwell below the current count causes an advance on the next edge, never a 2^DWELL_W stall.
- Manual (10): counter <= 0; advance on step_rise only.
- Advance:
  - Forward: idx <= (idx==NWIN-1) ? 0 : idx+1.
  - Backward: idx <= (idx==0) ? NWIN-1 : idx-1.
  - wrap <= 1 for exactly the cycle following a wrapping advance; 0 otherwise.
- NWIN=1: idx stays 0; every advance pulses wrap.
- dir change takes effect at the next advance; idx is not altered by the change itself.
- Mode change auto→manual clears counter. Manual→auto starts counting from 0.
- Padding bits in the top window always read 0.

Decomposition:
- Package led_scroll_pkg:
  - mode encodings MODE_PAUSE=2'b00, MODE_AUTO=2'b01, MODE_MANUAL=2'b10
  - functions nwin(N,W) (ceiling divide) and idx_w(NWIN) (clog2 with minimum 1)
- Sub-module dwell_timer (DWELL_W):
  - inputs clk, rst, clear, enable, dwell
  - output tick, asserted in the cycle counter >= dwell, with the counter returning to 0
  - the top level drives clear from load or manual mode, and enable from auto mode
- Top level: buffer, edge detector, index/wrap logic and output mux.

Test Plan:
All scenarios use N=20, W=8 (NWIN=3, IDX_W=2).
1. rst high mid-auto-scroll (idx=2) → leds=0x00, win_idx=0, wrap=0 asynchronously, before the next clk edge.
2. load data_in=20'hABCDE, mode=01, dir=0, dwell=3 → leds 0xDE for 4 cycles, then 0xBC, then 0x0A (padding zero), then 0xDE. wrap=1 for exactly one cycle, aligned with the return to idx 0.
3. Same data, mode=10, step held high 10 cycles then low, then pulsed twice → three advances total, idx 0→1→2→0. Single wrap pulse on the last advance.
4. Same data, mode=01, dir=1, dwell=0 → idx sequence 0,2,1,0,2… changes every cycle; wrap pulses on each 0→2 transition.
5. Auto, dwell=100, counter≈50; dwell changed to 10 → advance on the next edge, then period 11 cycles. Switch to mode=00 → idx frozen for 200 cycles, wrap stays 0.
6. load asserted in the same cycle an auto advance is due at idx=2 → idx=0, wrap stays 0, counter restarts. New data visible on leds the cycle after load.

Source files
------------

// File: rtl/led_word_scroller_pkg.sv
// ---------------------------------------------------------------------------
// led_scroll_pkg
// Shared definitions for the LED word scroller:
//   - display mode encodings (the fourth code behaves like pause)
//   - nwin()  : number of W-bit windows needed to cover an N-bit word
//   - idx_w() : width of a window index, never narrower than one bit
// ---------------------------------------------------------------------------
package led_scroll_pkg;

  localparam logic [1:0] MODE_PAUSE  = 2'b00;
  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_MANUAL = 2'b10;

  // Ceiling divide: a partial top window still counts as a window.
  function automatic int nwin(input int n, input int w);
    return (n + w - 1) / w;
  endfunction

  // A single window still needs a one-bit index to keep ports legal.
  function automatic int idx_w(input int nw);
    return (nw <= 1) ? 1 : $clog2(nw);
  endfunction

endpackage

// File: rtl/led_word_scroller_if.sv
// ---------------------------------------------------------------------------
// led_word_scroller_if
// Bundles the scroller's control inputs and display outputs.
//   load     : capture data_in (highest synchronous priority)
//   data_in  : N-bit word to display
//   mode     : 00 pause, 01 auto, 10 manual, 11 pause
//   dir      : 0 forward (index increments), 1 backward
//   step     : manual advance request, level, edge-detected inside
//   dwell    : auto-mode dwell; window period is dwell+1 cycles
//   leds     : current W-bit window of the zero-padded word
//   win_idx  : current window index
//   wrap     : one-cycle pulse after the index wraps
// Modports: master drives the controls, slave is the scroller itself.
// ---------------------------------------------------------------------------
interface led_word_scroller_if
  import led_scroll_pkg::*;
#(
  parameter int N       = 264,
  parameter int W       = 8,
  parameter int DWELL_W = 30
);

  localparam int NWIN  = nwin(N, W);
  localparam int IDX_W = idx_w(NWIN);

  logic               load;
  logic [N-1:0]       data_in;
  logic [1:0]         mode;
  logic               dir;
  logic               step;
  logic [DWELL_W-1:0] dwell;
  logic [W-1:0]       leds;
  logic [IDX_W-1:0]   win_idx;
  logic               wrap;

  modport master (
    output load, data_in, mode, dir, step, dwell,
    input  leds, win_idx, wrap
  );

  modport slave (
    input  load, data_in, mode, dir, step, dwell,
    output leds, win_idx, wrap
  );

endinterface

// File: rtl/led_word_scroller_dwell_timer.sv
// ---------------------------------------------------------------------------
// dwell_timer
// Free-running dwell counter for auto scrolling.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : force the counter to zero (load or manual mode)
//   enable   : count (auto mode); when low and not cleared the count holds
//   dwell    : threshold; tick fires when count >= dwell
//   tick     : advance request, counter returns to zero on the same edge
// Using >= rather than == means lowering dwell below the current count
// produces a tick on the next edge instead of a full-range rollover.
// ---------------------------------------------------------------------------
module dwell_timer #(
  parameter int DWELL_W = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tick
);

  logic [DWELL_W-1:0] r_count;
  logic               w_reached;

  assign w_reached = (r_count >= dwell);
  assign tick      = enable && !clear && w_reached;

  // The counter only increments while below dwell, so it can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      if (w_reached) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_word_scroller.sv
// ---------------------------------------------------------------------------
// led_word_scroller
// Captures an N-bit word and presents it W bits at a time on the LEDs.
// The word is zero-padded up to NWIN*W bits so N need not be a multiple of W.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : led_word_scroller_if slave (controls in, leds/win_idx/wrap out)
// Edge priority: rst > load > mode action. leds and win_idx decode the
// registered buffer/index combinationally, so they follow the registers
// with no extra latency.
// ---------------------------------------------------------------------------
module led_word_scroller
  import led_scroll_pkg::*;
#(
  parameter int N       = 264,
  parameter int W       = 8,
  parameter int DWELL_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  led_word_scroller_if.slave bus
);

  localparam int NWIN  = nwin(N, W);
  localparam int IDX_W = idx_w(NWIN);
  localparam int PAD_W = NWIN * W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWIN - 1);

  // Registered state
  logic [N-1:0]     r_buffer;
  logic [IDX_W-1:0] r_idx;
  logic             r_step_q;
  logic             r_wrap;

  // Combinational helpers
  logic [IDX_W-1:0] w_idx_next;
  logic             w_wrap_next;
  logic             w_auto;
  logic             w_manual;
  logic             w_step_rise;
  logic             w_tick;
  logic             w_advance;
  logic [PAD_W-1:0] w_padded;
  logic [W-1:0]     w_win [NWIN];
  logic [W-1:0]     w_leds;

  // Mode decode: anything other than auto/manual (including 2'b11) pauses.
  assign w_auto   = (bus.mode == MODE_AUTO);
  assign w_manual = (bus.mode == MODE_MANUAL);

  // step_q tracks step in every mode, so entering manual with step already
  // high sees no rising edge.
  assign w_step_rise = bus.step && !r_step_q;

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (bus.load || w_manual),
    .enable (w_auto),
    .dwell  (bus.dwell),
    .tick   (w_tick)
  );

  // A load on the same edge swallows any advance that was due.
  assign w_advance = !bus.load &&
                     ((w_auto && w_tick) || (w_manual && w_step_rise));

  // Next index and wrap flag. With NWIN=1 the index is both first and last,
  // so it stays at 0 and every advance reports a wrap.
  always_comb begin
    w_idx_next  = r_idx;
    w_wrap_next = 1'b0;
    if (w_advance) begin
      if (!bus.dir) begin
        if (r_idx == LAST_IDX) begin
          w_idx_next  = '0;
          w_wrap_next = 1'b1;
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end else begin
        if (r_idx == '0) begin
          w_idx_next  = LAST_IDX;
          w_wrap_next = 1'b1;
        end else begin
          w_idx_next = r_idx - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buffer <= '0;
      r_idx    <= '0;
      r_step_q <= 1'b0;
      r_wrap   <= 1'b0;
    end else if (bus.load) begin
      r_buffer <= bus.data_in;
      r_idx    <= '0;
      r_step_q <= bus.step;
      r_wrap   <= 1'b0;
    end else begin
      r_idx    <= w_idx_next;
      r_step_q <= bus.step;
      r_wrap   <= w_wrap_next;
    end
  end

  // Zero-extend the stored word to a whole number of windows; the pad bits
  // are constant zero, so the top window's unused LEDs are always dark.
  always_comb begin
    w_padded          = '0;
    w_padded[N-1:0]   = r_buffer;
  end

  generate
    for (genvar gi = 0; gi < NWIN; gi++) begin : g_win
      assign w_win[gi] = w_padded[gi*W +: W];
    end
  endgenerate

  // Compare-based select avoids indexing the window array with an index
  // wider than the array needs.
  always_comb begin
    w_leds = '0;
    for (int i = 0; i < NWIN; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_leds = w_win[i];
      end
    end
  end

  assign bus.leds    = w_leds;
  assign bus.win_idx = r_idx;
  assign bus.wrap    = r_wrap;

endmodule

// File: tb/tb_led_word_scroller.sv
// ---------------------------------------------------------------------------
// tb_led_word_scroller
// Randomised and directed stimulus against a cycle-level reference model of
// the scroller (N=20, W=8, three windows). The driver pushes the predicted
// display state for every clock into a queue; a monitor pops and compares
// one entry just after each rising edge.
// ---------------------------------------------------------------------------
module tb_led_word_scroller;

  localparam int N       = 20;
  localparam int W       = 8;
  localparam int DWELL_W = 30;
  localparam int NW      = 3;

  typedef struct {
    logic [7:0] leds;
    logic [1:0] idx;
    logic       wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_word_scroller_if #(.N(N), .W(W), .DWELL_W(DWELL_W)) bus ();

  led_word_scroller #(.N(N), .W(W), .DWELL_W(DWELL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   drv_done = 1'b0;

  // Reference model state
  logic [23:0] m_data;
  int          m_idx;
  longint      m_cnt;
  bit          m_stepq;
  bit          m_wrap;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model_view();
    exp_t e;
    e.leds = 8'((m_data >> (m_idx * 8)) & 24'hFF);
    e.idx  = 2'(m_idx);
    e.wrap = m_wrap;
    return e;
  endfunction

  // One clock edge of the specified behaviour.
  function automatic void model_step(input bit r, input bit ld, input logic [19:0] d,
                                     input logic [1:0] md, input bit dr, input bit st,
                                     input longint dw);
    bit adv;
    if (r) begin
      m_data = '0; m_idx = 0; m_cnt = 0; m_stepq = 0; m_wrap = 0;
      return;
    end
    if (ld) begin
      m_data  = {4'h0, d};
      m_idx   = 0;
      m_cnt   = 0;
      m_wrap  = 0;
      m_stepq = st;
      return;
    end
    adv = 0;
    if (md == 2'b01) begin
      if (m_cnt >= dw) begin m_cnt = 0; adv = 1; end
      else m_cnt = m_cnt + 1;
    end else if (md == 2'b10) begin
      m_cnt = 0;
      adv = st && !m_stepq;
    end
    m_wrap = 0;
    if (adv) begin
      if (!dr) begin
        m_idx  = (m_idx + 1) % NW;
        m_wrap = (m_idx == 0);
      end else begin
        m_wrap = (m_idx == 0);
        m_idx  = (m_idx + NW - 1) % NW;
      end
    end
    m_stepq = st;
  endfunction

  // Applies one cycle of inputs at the falling edge and queues the
  // prediction for the following rising edge.
  task automatic drive(input bit r, input bit ld, input logic [19:0] d,
                       input logic [1:0] md, input bit dr, input bit st,
                       input logic [29:0] dw);
    @(negedge clk);
    rst         = r;
    bus.load    = ld;
    bus.data_in = d;
    bus.mode    = md;
    bus.dir     = dr;
    bus.step    = st;
    bus.dwell   = dw;
    if (r) begin
      // Reset must clear the outputs without waiting for a clock edge.
      #1;
      chk("async_rst_leds", int'(bus.leds), 0);
      chk("async_rst_idx",  int'(bus.win_idx), 0);
      chk("async_rst_wrap", int'(bus.wrap), 0);
    end
    model_step(r, ld, d, md, dr, st, longint'(dw));
    exp_q.push_back(model_view());
  endtask

  // Monitor: the display state is valid every cycle after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("leds",    int'(bus.leds),    int'(e.leds));
        chk("win_idx", int'(bus.win_idx), int'(e.idx));
        chk("wrap",    int'(bus.wrap),    int'(e.wrap));
      end
    end
  end

  initial begin
    logic [19:0] d;
    logic [1:0]  md;
    bit          dr, st, ld, r;
    logic [29:0] dw;
    int          guard;

    bus.load = 0; bus.data_in = '0; bus.mode = '0; bus.dir = 0;
    bus.step = 0; bus.dwell = '0;
    m_data = '0; m_idx = 0; m_cnt = 0; m_stepq = 0; m_wrap = 0;

    drive(1, 0, 20'h0, 2'b00, 0, 0, 30'd0);
    drive(1, 0, 20'h0, 2'b00, 0, 0, 30'd0);

    // Auto forward scroll, dwell 3.
    drive(0, 1, 20'hABCDE, 2'b01, 0, 0, 30'd3);
    for (int i = 0; i < 20; i++) drive(0, 0, 20'hABCDE, 2'b01, 0, 0, 30'd3);

    // Reset in the middle of an auto scroll with the index at 2.
    guard = 0;
    while (m_idx != 2 && guard < 20) begin
      drive(0, 0, 20'hABCDE, 2'b01, 0, 0, 30'd3);
      guard++;
    end
    chk("reach_idx2_before_rst", m_idx, 2);
    drive(1, 0, 20'hABCDE, 2'b01, 0, 0, 30'd3);
    drive(1, 0, 20'hABCDE, 2'b01, 0, 0, 30'd3);

    // Manual: step held, then two pulses.
    drive(0, 1, 20'hABCDE, 2'b10, 0, 0, 30'd3);
    for (int i = 0; i < 10; i++) drive(0, 0, 20'hABCDE, 2'b10, 0, 1, 30'd3);
    for (int i = 0; i < 3; i++)  drive(0, 0, 20'hABCDE, 2'b10, 0, 0, 30'd3);
    for (int p = 0; p < 2; p++) begin
      drive(0, 0, 20'hABCDE, 2'b10, 0, 1, 30'd3);
      drive(0, 0, 20'hABCDE, 2'b10, 0, 0, 30'd3);
      drive(0, 0, 20'hABCDE, 2'b10, 0, 0, 30'd3);
    end

    // Auto backward, dwell 0.
    drive(0, 1, 20'hABCDE, 2'b01, 1, 0, 30'd0);
    for (int i = 0; i < 10; i++) drive(0, 0, 20'hABCDE, 2'b01, 1, 0, 30'd0);

    // Dwell lowered below the running count, then pause.
    drive(0, 1, 20'hABCDE, 2'b01, 0, 0, 30'd100);
    for (int i = 0; i < 50; i++)  drive(0, 0, 20'hABCDE, 2'b01, 0, 0, 30'd100);
    for (int i = 0; i < 30; i++)  drive(0, 0, 20'hABCDE, 2'b01, 0, 0, 30'd10);
    for (int i = 0; i < 200; i++) drive(0, 0, 20'hABCDE, 2'b00, 0, 0, 30'd10);

    // Load colliding with a due advance at index 2.
    drive(0, 1, 20'hABCDE, 2'b01, 0, 0, 30'd2);
    guard = 0;
    while (!(m_idx == 2 && m_cnt == 2) && guard < 40) begin
      drive(0, 0, 20'hABCDE, 2'b01, 0, 0, 30'd2);
      guard++;
    end
    chk("reach_due_at_idx2", m_idx * 10 + int'(m_cnt), 22);
    drive(0, 1, 20'h13579, 2'b01, 0, 0, 30'd2);
    for (int i = 0; i < 10; i++) drive(0, 0, 20'h13579, 2'b01, 0, 0, 30'd2);

    // Random phase.
    d = 20'h0; md = 2'b01; dr = 0; st = 0; dw = 30'd1;
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 19) == 0);
      if (ld) d = 20'($urandom);
      if ($urandom_range(0, 15) == 0) md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)  dr = ~dr;
      if ($urandom_range(0, 2) == 0)  st = ~st;
      if ($urandom_range(0, 11) == 0) dw = 30'($urandom_range(0, 4));
      drive(r, ld, d, md, dr, st, dw);
    end

    drv_done = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
